// File: rtl/tdr_pkg.sv
//-----------------------------------------------------------------------------
// tdr_pkg
// Shared types and defaults for the time-domain register cell.
//   tdr_state_e    : cell state (EMPTY, WRITE, FULL, READ)
//   CNT_W_DEFAULT  : default counter / storage width
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
package tdr_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2,
    READ  = 2'd3
  } tdr_state_e;

  localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/tdr_if.sv
//-----------------------------------------------------------------------------
// tdr_if
// Strobe / output bundle of one time-domain register cell.
//   WE0_i   : write start strobe (level)
//   WE1_i   : write stop strobe (level)
//   RE_i    : read strobe (level)
//   carry_o : sticky overflow flag of the last write
//   out_o   : replay pulse
// Modports: master drives the strobes, slave is the cell.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
interface tdr_if;

  logic WE0_i;
  logic WE1_i;
  logic RE_i;
  logic carry_o;
  logic out_o;

  modport master (
    output WE0_i,
    output WE1_i,
    output RE_i,
    input  carry_o,
    input  out_o
  );

  modport slave (
    input  WE0_i,
    input  WE1_i,
    input  RE_i,
    output carry_o,
    output out_o
  );

endinterface

// File: rtl/tdr_edge_det.sv
//-----------------------------------------------------------------------------
// tdr_edge_det
// One-bit rising-edge detector with a single history flop.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (clears history)
//   i_d    : strobe level, already synchronous to i_clk
//   o_rise : high in the cycle where i_d is 1 and was 0 on the last edge
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tdr_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  // History flop: strobe level seen on the previous clock edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/time_domain_reg.sv
//-----------------------------------------------------------------------------
// time_domain_reg
// Time-domain memory cell: records the number of clock edges between a
// write-start and a write-stop strobe, and replays that count as a single
// high pulse on a read strobe.
//   clk_i : clock, all state changes on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : tdr_if.slave (WE0_i, WE1_i, RE_i in; carry_o, out_o out)
// Parameter CNT_W: counter/storage width (max interval 2**CNT_W-1 cycles).
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module time_domain_reg
  import tdr_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic  clk_i,
  input  logic  rst_i,
  tdr_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  tdr_state_e        r_state;
  tdr_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  r_stored;
  logic [CNT_W-1:0]  w_stored_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              r_carry;
  logic              w_carry_nxt;
  logic              r_out;
  logic              w_out_nxt;
  logic              w_rise_we0;
  logic              w_rise_we1;
  logic              w_rise_re;
  logic              w_cnt_all_ones;
  logic              w_stored_zero;

  tdr_edge_det u_edge_we0 (.i_clk(clk_i), .i_rst(rst_i), .i_d(bus.WE0_i), .o_rise(w_rise_we0));
  tdr_edge_det u_edge_we1 (.i_clk(clk_i), .i_rst(rst_i), .i_d(bus.WE1_i), .o_rise(w_rise_we1));
  tdr_edge_det u_edge_re  (.i_clk(clk_i), .i_rst(rst_i), .i_d(bus.RE_i),  .o_rise(w_rise_re));

  // The stop edge itself is counted, so the stored interval equals the
  // number of edges from the start sample to the stop sample.
  assign w_cnt_inc      = r_cnt + CNT_ONE;
  assign w_cnt_all_ones = &r_cnt;
  assign w_stored_zero  = (r_stored == CNT_ZERO);

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= EMPTY;
      r_cnt    <= CNT_ZERO;
      r_stored <= CNT_ZERO;
      r_carry  <= 1'b0;
      r_out    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_stored <= w_stored_nxt;
      r_carry  <= w_carry_nxt;
      r_out    <= w_out_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY, FULL: begin
        if (w_rise_we0 && w_rise_we1) begin
          w_state_nxt = FULL;
        end else if (w_rise_we0) begin
          w_state_nxt = WRITE;
        end else if ((r_state == FULL) && w_rise_re && !w_stored_zero) begin
          // A zero-length interval has nothing to replay; stay in FULL.
          w_state_nxt = READ;
        end else begin
          w_state_nxt = r_state;
        end
      end
      WRITE: begin
        if (w_rise_we1) begin
          w_state_nxt = FULL;
        end else begin
          w_state_nxt = WRITE;
        end
      end
      READ: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = FULL;
        end else begin
          w_state_nxt = READ;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  // Counter, stored value, carry and output next values
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_stored_nxt = r_stored;
    w_carry_nxt  = r_carry;
    w_out_nxt    = 1'b0;
    case (r_state)
      EMPTY, FULL: begin
        if (w_rise_we0) begin
          w_cnt_nxt   = CNT_ZERO;
          w_carry_nxt = 1'b0;
          if (w_rise_we1) begin
            w_stored_nxt = CNT_ZERO;
          end else begin
            w_stored_nxt = r_stored;
          end
        end else if ((r_state == FULL) && w_rise_re) begin
          // Preload the down-counter; the pulse starts on the next edge.
          w_cnt_nxt = r_stored;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      WRITE: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_cnt_all_ones) begin
          w_carry_nxt = 1'b1;
        end else begin
          w_carry_nxt = r_carry;
        end
        if (w_rise_we1) begin
          w_stored_nxt = w_cnt_inc;
        end else begin
          w_stored_nxt = r_stored;
        end
      end
      READ: begin
        // One high cycle per remaining count, then drop and return to FULL.
        if (r_cnt != CNT_ZERO) begin
          w_out_nxt = 1'b1;
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else begin
          w_out_nxt = 1'b0;
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_cnt_nxt = CNT_ZERO;
      end
    endcase
  end

  assign bus.carry_o = r_carry;
  assign bus.out_o   = r_out;

endmodule

// File: tb/tb_time_domain_reg.sv
`timescale 1ns/1ps
module tb_time_domain_reg;

  localparam int CW   = 8;
  localparam int MAXV = 1 << CW;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  tdr_if u_if();

  time_domain_reg #(.CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_if.slave)
  );

  always #0.5 clk = ~clk;

  // Write an interval of n edges between start and stop samples.
  // retrig re-raises WE0 mid-write (must be ignored).
  task automatic do_write(input int n, input bit retrig, output bit c_start, output bit c_end);
    @(negedge clk);
    u_if.WE0_i = 1'b1;
    if (n == 0) u_if.WE1_i = 1'b1;
    @(negedge clk);
    c_start = u_if.carry_o;
    u_if.WE0_i = 1'b0;
    if (n == 0) begin
      u_if.WE1_i = 1'b0;
      c_end = u_if.carry_o;
    end else begin
      for (int k = 1; k < n; k++) begin
        @(negedge clk);
        if (retrig && (k == n / 2)) u_if.WE0_i = 1'b1;
      end
      u_if.WE1_i = 1'b1;
      @(negedge clk);
      c_end = u_if.carry_o;
      u_if.WE0_i = 1'b0;
      u_if.WE1_i = 1'b0;
    end
  endtask

  // Raise RE once and record the out_o waveform over budget edges.
  // fst = edge offset (from the RE sample edge) of the first high sample.
  task automatic do_read(input int budget, input int poke_k,
                         output int fst, output int nhi, output int nseg, output bit moved);
    logic c0;
    logic prev;
    @(negedge clk);
    c0 = u_if.carry_o;
    u_if.RE_i = 1'b1;
    fst = -1; nhi = 0; nseg = 0; moved = 1'b0; prev = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (k == 0) u_if.RE_i = 1'b0;
      if (poke_k >= 0) begin
        if (k == poke_k) u_if.WE0_i = 1'b1;
        else if (k == poke_k + 1) u_if.WE0_i = 1'b0;
      end
      if (u_if.out_o === 1'b1) begin
        nhi++;
        if (fst < 0) fst = k;
        if (prev !== 1'b1) nseg++;
      end
      prev = u_if.out_o;
      if (u_if.carry_o !== c0) moved = 1'b1;
    end
  endtask

  task automatic test_reset();
    int fst, nhi, nseg;
    bit moved;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      u_if.WE0_i = 1'($urandom_range(0, 1));
      u_if.WE1_i = 1'($urandom_range(0, 1));
      u_if.RE_i  = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (u_if.out_o !== 1'b0) begin errors++; $display("FAIL reset_out: got %b expected 0", u_if.out_o); end
      checks++;
      if (u_if.carry_o !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", u_if.carry_o); end
    end
    u_if.WE0_i = 1'b0; u_if.WE1_i = 1'b0; u_if.RE_i = 1'b0;
    rst = 1'b0;
    do_read(8, -1, fst, nhi, nseg, moved);
    checks++;
    if (nhi !== 0) begin errors++; $display("FAIL reset_read_empty: got %0d high cycles expected 0", nhi); end
  endtask

  task automatic test_basic();
    int fst, nhi, nseg;
    bit moved, cs, ce;
    do_write(5, 1'b0, cs, ce);
    checks++;
    if (ce !== 1'b0) begin errors++; $display("FAIL basic_carry: got %b expected 0", ce); end
    do_read(9, -1, fst, nhi, nseg, moved);
    checks++;
    if (nhi !== 5) begin errors++; $display("FAIL basic_len: got %0d expected 5", nhi); end
    checks++;
    if (fst !== 1) begin errors++; $display("FAIL basic_start: got offset %0d expected 1", fst); end
    checks++;
    if (nseg !== 1) begin errors++; $display("FAIL basic_segments: got %0d expected 1", nseg); end
  endtask

  task automatic test_repeat_read();
    int fst, nhi, nseg;
    bit moved;
    do_read(9, -1, fst, nhi, nseg, moved);
    checks++;
    if (nhi !== 5) begin errors++; $display("FAIL repeat_len: got %0d expected 5", nhi); end
    checks++;
    if (fst !== 1) begin errors++; $display("FAIL repeat_start: got offset %0d expected 1", fst); end
  endtask

  task automatic test_overflow();
    int fst, nhi, nseg;
    bit moved, cs, ce;
    logic exp_c;
    @(negedge clk);
    u_if.WE0_i = 1'b1;
    // k counts edges after the start sample; stop sampled 258 edges after start
    for (int k = 0; k <= 257; k++) begin
      @(negedge clk);
      if (k == 0) u_if.WE0_i = 1'b0;
      exp_c = (k >= MAXV);
      checks++;
      if (u_if.carry_o !== exp_c) begin
        errors++; $display("FAIL ovf_carry_k%0d: got %b expected %b", k, u_if.carry_o, exp_c);
      end
      if (k == 257) u_if.WE1_i = 1'b1;
    end
    @(negedge clk);
    u_if.WE1_i = 1'b0;
    checks++;
    if (u_if.carry_o !== 1'b1) begin errors++; $display("FAIL ovf_carry_end: got %b expected 1", u_if.carry_o); end
    do_read(6, -1, fst, nhi, nseg, moved);
    checks++;
    if (nhi !== 2) begin errors++; $display("FAIL ovf_len: got %0d expected 2", nhi); end
    checks++;
    if (moved !== 1'b0) begin errors++; $display("FAIL ovf_carry_read: carry changed during read, expected stable"); end
    do_write(3, 1'b0, cs, ce);
    checks++;
    if (cs !== 1'b0) begin errors++; $display("FAIL ovf_carry_clear: got %b expected 0", cs); end
    do_read(7, -1, fst, nhi, nseg, moved);
    checks++;
    if (nhi !== 3) begin errors++; $display("FAIL ovf_next_len: got %0d expected 3", nhi); end
  endtask

  task automatic test_ignored();
    int fst, nhi, nseg;
    bit moved, cs, ce;
    // RE while EMPTY
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_read(6, -1, fst, nhi, nseg, moved);
    checks++;
    if (nhi !== 0) begin errors++; $display("FAIL empty_read: got %0d expected 0", nhi); end
    // WE0 and WE1 together
    do_write(0, 1'b0, cs, ce);
    do_read(6, -1, fst, nhi, nseg, moved);
    checks++;
    if (nhi !== 0) begin errors++; $display("FAIL simul_read: got %0d expected 0", nhi); end
    // WE0 during READ
    do_write(5, 1'b0, cs, ce);
    do_read(9, 2, fst, nhi, nseg, moved);
    checks++;
    if (nhi !== 5) begin errors++; $display("FAIL we0_in_read_len: got %0d expected 5", nhi); end
    do_read(9, -1, fst, nhi, nseg, moved);
    checks++;
    if (nhi !== 5) begin errors++; $display("FAIL we0_in_read_after: got %0d expected 5", nhi); end
    // WE1 outside WRITE
    @(negedge clk);
    u_if.WE1_i = 1'b1;
    @(negedge clk);
    u_if.WE1_i = 1'b0;
    do_read(9, -1, fst, nhi, nseg, moved);
    checks++;
    if (nhi !== 5) begin errors++; $display("FAIL we1_in_full: got %0d expected 5", nhi); end
    // WE0 re-raised during WRITE
    do_write(7, 1'b1, cs, ce);
    do_read(11, -1, fst, nhi, nseg, moved);
    checks++;
    if (nhi !== 7) begin errors++; $display("FAIL we0_in_write: got %0d expected 7", nhi); end
  endtask

  task automatic test_random();
    int fst, nhi, nseg;
    bit moved, cs, ce;
    for (int it = 0; it < 8; it++) begin
      int n;
      int exp_len;
      bit exp_carry;
      bit rt;
      if (it == 0) n = MAXV - 1;
      else if (it == 1) n = MAXV;
      else n = $urandom_range(0, 300);
      rt = 1'($urandom_range(0, 1));
      exp_len = n % MAXV;
      exp_carry = (n >= MAXV);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_write(n, rt, cs, ce);
      checks++;
      if (cs !== 1'b0) begin errors++; $display("FAIL rnd%0d_carry_start: got %b expected 0", it, cs); end
      checks++;
      if (ce !== exp_carry) begin errors++; $display("FAIL rnd%0d_carry (n=%0d): got %b expected %b", it, n, ce, exp_carry); end
      do_read(exp_len + 4, -1, fst, nhi, nseg, moved);
      checks++;
      if (nhi !== exp_len) begin errors++; $display("FAIL rnd%0d_len (n=%0d): got %0d expected %0d", it, n, nhi, exp_len); end
      checks++;
      if (moved !== 1'b0) begin errors++; $display("FAIL rnd%0d_carry_read: carry changed during read", it); end
      if (exp_len > 0) begin
        checks++;
        if (fst !== 1) begin errors++; $display("FAIL rnd%0d_start: got offset %0d expected 1", it, fst); end
        checks++;
        if (nseg !== 1) begin errors++; $display("FAIL rnd%0d_segments: got %0d expected 1", it, nseg); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int fst, nhi, nseg;
    bit moved, cs, ce;
    do_write(5, 1'b0, cs, ce);
    @(negedge clk);
    u_if.RE_i = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 0) u_if.RE_i = 1'b0;
      if ((k == 1) || (k == 2)) begin
        checks++;
        if (u_if.out_o !== 1'b1) begin errors++; $display("FAIL midrd_pulse_k%0d: got %b expected 1", k, u_if.out_o); end
      end
      if (k == 2) rst = 1'b1;
      if (k == 3) begin
        checks++;
        if (u_if.out_o !== 1'b0) begin errors++; $display("FAIL midrd_out_reset: got %b expected 0", u_if.out_o); end
        rst = 1'b0;
      end
    end
    do_read(9, -1, fst, nhi, nseg, moved);
    checks++;
    if (nhi !== 0) begin errors++; $display("FAIL midrd_read_after: got %0d expected 0", nhi); end
    checks++;
    if (u_if.carry_o !== 1'b0) begin errors++; $display("FAIL midrd_carry: got %b expected 0", u_if.carry_o); end
  endtask

  initial begin
    rst = 1'b1;
    u_if.WE0_i = 1'b0;
    u_if.WE1_i = 1'b0;
    u_if.RE_i  = 1'b0;
    test_reset();
    test_basic();
    test_repeat_read();
    test_overflow();
    test_ignored();
    test_random();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
